// File: rtl/problemalcd_botoes_ctrl_if.sv
// Avalon-MM register bus between the interconnect and the button controller.
interface problemalcd_botoes_ctrl_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/problemalcd_botoes_ctrl.sv
// Push-button controller: synchronise, debounce, capture press edges,
// queue press events in a FIFO and raise a maskable interrupt.
module problemalcd_botoes_ctrl #(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  problemalcd_botoes_ctrl_if.slave   bus,
  input  logic [NUM_BUTTONS-1:0]     in_port,
  output logic                       irq,
  output logic [NUM_BUTTONS-1:0]     pressed
);

  localparam int unsigned N     = NUM_BUTTONS;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     level;
  logic [N-1:0]     s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     pressed_q, pressed_d, prev_q, prev_d;
  logic [N-1:0]     ec_q, ec_d, pending_q, pending_d, mask_q, mask_d;
  logic             mask31_q, mask31_d, ov_q, ov_d, irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;

  logic             empty, full, pop, push;
  logic [N-1:0]     rise, push_sel;
  logic [7:0]       push_idx, head;

  // Raw pins converted to a press-is-1 level.
  assign level = (ACTIVE_LOW != 0) ? ~in_port : in_port;

  assign irq          = irq_q;
  assign pressed      = pressed_q;
  assign bus.readdata = readdata_q;

  // Write-data bits outside the decoded fields are intentionally ignored.
  logic unused_wd;
  assign unused_wd = &{1'b0, bus.writedata};

  // Next-state logic for conditioning, event capture, FIFO and registers.
  always_comb begin
    s1_d       = level;
    s2_d       = s1_q;
    pressed_d  = pressed_q;
    prev_d     = pressed_q;
    ec_d       = ec_q;
    pending_d  = pending_q;
    mask_d     = mask_q;
    mask31_d   = mask31_q;
    ov_d       = ov_q;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    push_sel   = '0;
    push_idx   = '0;
    readdata_d = '0;

    // Debounce: a level change is accepted after DEBOUNCE_CYCLES stable cycles.
    for (int i = 0; i < int'(N); i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != pressed_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          pressed_d[i] = ~pressed_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    rise = pressed_q & ~prev_q;

    // FIFO status and head.
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
            (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    head  = empty ? 8'd0 : mem_q[rptr_q[PTR_W-1:0]];
    pop   = bus.read && (bus.address == 2'd1) && !empty;

    // Lowest-index pending button wins the single push slot.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_sel    = '0;
        push_sel[i] = 1'b1;
        push_idx    = 8'(i);
      end
    end
    push = (|pending_q) && (!full || pop);
    if (!push) begin
      push_sel = '0;
    end

    if (push) begin
      mem_d[wptr_q[PTR_W-1:0]] = push_idx;
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end

    // A press on a bit that is still queued merges and flags overflow.
    pending_d = (pending_q & ~push_sel) | rise;

    if (bus.write && (bus.address == 2'd1) && bus.writedata[9]) begin
      ov_d = 1'b0;
    end
    if (|(rise & pending_q & ~push_sel)) begin
      ov_d = 1'b1;
    end

    if (bus.write && (bus.address == 2'd2)) begin
      mask_d   = bus.writedata[N-1:0];
      mask31_d = bus.writedata[31];
    end

    if (bus.write && (bus.address == 2'd3)) begin
      ec_d = ec_q & ~bus.writedata[N-1:0];
    end
    ec_d = ec_d | rise;

    irq_d = (|(ec_q & mask_q)) | (ov_q & mask31_q);

    case (bus.address)
      2'd0:    readdata_d = 32'(pressed_q);
      2'd1:    readdata_d = {22'd0, ov_q, ~empty, head};
      2'd2:    readdata_d = {mask31_q, 31'(mask_q)};
      default: readdata_d = 32'(ec_q);
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
      pressed_q  <= '0;
      prev_q     <= '0;
      ec_q       <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      mask31_q   <= 1'b0;
      ov_q       <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cnt_q      <= cnt_d;
      pressed_q  <= pressed_d;
      prev_q     <= prev_d;
      ec_q       <= ec_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      mask31_q   <= mask31_d;
      ov_q       <= ov_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

endmodule
